// File: rtl/decrypter_out.sv
// Buffers decrypted 32-bit words and serialises them MSB-first to a UART byte handshake.
// Optional build macro DECRYPTER_OUT_ZERO_STRIP_EN drops 0x00 bytes instead of sending them.
module decrypter_out #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        len_valid,
    input  logic [31:0] len_in,
    input  logic        fme_done,
    input  logic [31:0] fme_data_out,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [31:0] words_sent
);

    typedef enum logic [2:0] {IDLE, WAIT_LEN, RUN, SEND, GAP} state_t;

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t             state;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [31:0]        shift;
    logic [1:0]         byte_idx;
    logic [31:0]        len;
    logic               len_latched;
    logic [31:0]        words_received;

    logic fifo_full;
    logic pop;
    logic push_req;
    logic len_reached;
    logic push;
    logic byte_done;

    assign fifo_full   = (count == FULL_COUNT);
    assign pop         = (state == RUN) && (count != '0);
    assign push_req    = fme_done && (state != IDLE);
    assign len_reached = len_latched && (words_received == len);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push        = push_req && !len_reached && (!fifo_full || pop);
    assign busy        = (state != IDLE);

`ifdef DECRYPTER_OUT_ZERO_STRIP_EN
    assign byte_done = (state == GAP) || ((state == SEND) && (shift[31:24] == 8'h00));
`else
    assign byte_done = (state == GAP);
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= fme_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            shift          <= '0;
            byte_idx       <= '0;
            len            <= '0;
            len_latched    <= 1'b0;
            words_received <= '0;
            words_sent     <= '0;
            tx_start       <= 1'b0;
            tx_data        <= '0;
            done           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state          <= WAIT_LEN;
                    wr_ptr         <= '0;
                    rd_ptr         <= '0;
                    count          <= '0;
                    len            <= '0;
                    len_latched    <= 1'b0;
                    words_received <= '0;
                    words_sent     <= '0;
                    overflow       <= 1'b0;
                end
            end else begin
                if (push) begin
                    wr_ptr         <= wr_ptr + 1'b1;
                    words_received <= words_received + 32'd1;
                end
                if (push_req && !push) begin
                    overflow <= 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end

                case (state)
                    WAIT_LEN: begin
                        if (len_valid) begin
                            len         <= len_in;
                            len_latched <= 1'b1;
                            if (len_in == 32'd0) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (pop) begin
                            shift    <= fifo_mem[rd_ptr];
                            byte_idx <= '0;
                            state    <= SEND;
                        end
                    end
                    SEND: begin
                        if (!byte_done && tx_ready) begin
                            tx_data  <= shift[31:24];
                            tx_start <= 1'b1;
                            state    <= GAP;
                        end
                    end
                    default: ;
                endcase

                // Shared byte accounting for a sent byte (GAP) or a stripped one.
                if (byte_done) begin
                    shift    <= shift << 8;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        words_sent <= words_sent + 32'd1;
                        if (words_sent + 32'd1 == len) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= SEND;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decrypter_out.sv
// Directed bench for decrypter_out: byte order, latency, zero length, back-pressure,
// overflow, mid-transfer reset and the zero-strip build option.
module tb_decrypter_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        len_valid = 1'b0;
    logic [31:0] len_in = '0;
    logic        fme_done = 1'b0;
    logic [31:0] fme_data_out = '0;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] words_sent;

    int asserts = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic [7:0] bytes [$];
    int         start_cyc [$];

    decrypter_out #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .len_valid(len_valid), .len_in(len_in),
        .fme_done(fme_done), .fme_data_out(fme_data_out), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done),
        .overflow(overflow), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            bytes.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        bytes.delete();
        start_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic begin_session(input logic [31:0] len);
        start = 1'b1;
        step();
        start = 1'b0;
        len_in = len;
        len_valid = 1'b1;
        step();
        len_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        fme_data_out = w;
        fme_done = 1'b1;
        step();
        fme_done = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        step(2);
        asserts++;
        if ({tx_start, done, busy, overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: {tx_start,done,busy,overflow}=%b required 0000", {tx_start, done, busy, overflow});
        end
        asserts++;
        if (tx_data !== 8'h00 || words_sent !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: tx_data=%h words_sent=%0d required 00 and 0", tx_data, words_sent);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        logic [7:0]  got;
        int t0;
        w = 32'h48656C6C;
        clear_log();
        tx_ready = 1'b1;
        begin_session(32'd1);
        step(2);
        t0 = cyc;
        push_word(w);
        wait_done(60);
        step(2);
        asserts++;
        if (start_cyc.size() < 1 || start_cyc[0] != t0 + 3) begin
            failures++;
            $display("FAIL single_latency: first tx_start cycle=%0d required %0d", (start_cyc.size() > 0) ? start_cyc[0] : -1, t0 + 3);
        end
        asserts++;
        if (bytes.size() != 4) begin
            failures++;
            $display("FAIL single_count: bytes=%0d required 4", bytes.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes.size()) ? bytes[i] : 8'hxx;
            asserts++;
            if (got !== w[31-8*i -: 8]) begin
                failures++;
                $display("FAIL single_byte%0d: got %h required %h", i, got, w[31-8*i -: 8]);
            end
        end
        asserts++;
        if (start_cyc.size() < 2 || start_cyc[1] - start_cyc[0] != 2) begin
            failures++;
            $display("FAIL single_spacing: tx_start spacing wrong, starts seen=%0d required spacing 2", start_cyc.size());
        end
        asserts++;
        if (done_cnt != 1 || start_cyc.size() != 4 || done_cyc != start_cyc[3] + 1) begin
            failures++;
            $display("FAIL single_done: done_cnt=%0d done_cyc=%0d required 1 pulse right after last byte", done_cnt, done_cyc);
        end
        asserts++;
        if (words_sent !== 32'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_final: words_sent=%0d busy=%b required 1 and 0", words_sent, busy);
        end
    endtask

    task automatic test_zero_len();
        int tl;
        clear_log();
        start = 1'b1;
        step();
        start = 1'b0;
        len_in = 32'd0;
        len_valid = 1'b1;
        tl = cyc;
        step();
        len_valid = 1'b0;
        step(3);
        asserts++;
        if (done_cnt != 1 || done_cyc != tl + 1) begin
            failures++;
            $display("FAIL zero_len_done: done_cnt=%0d done_cyc=%0d required 1 at %0d", done_cnt, done_cyc, tl + 1);
        end
        asserts++;
        if (bytes.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_idle: bytes=%0d busy=%b required 0 and 0", bytes.size(), busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [2];
        logic [7:0]  got;
        logic [7:0]  exp_b;
        w[0] = 32'h11223344;
        w[1] = 32'hA5B6C7D8;
        clear_log();
        tx_ready = 1'b0;
        begin_session(32'd2);
        push_word(w[0]);
        push_word(w[1]);
        step(100);
        asserts++;
        if (bytes.size() != 0) begin
            failures++;
            $display("FAIL b2b_stall: bytes=%0d while tx_ready low, required 0", bytes.size());
        end
        tx_ready = 1'b1;
        wait_done(100);
        step(2);
        asserts++;
        if (bytes.size() != 8) begin
            failures++;
            $display("FAIL b2b_count: bytes=%0d required 8", bytes.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < bytes.size()) ? bytes[i] : 8'hxx;
            exp_b = w[i/4][31-8*(i%4) -: 8];
            asserts++;
            if (got !== exp_b) begin
                failures++;
                $display("FAIL b2b_byte%0d: got %h required %h", i, got, exp_b);
            end
        end
        asserts++;
        if (done_cnt != 1 || start_cyc.size() != 8 || done_cyc != start_cyc[7] + 1) begin
            failures++;
            $display("FAIL b2b_done: done_cnt=%0d done_cyc=%0d required 1 pulse after 8th byte", done_cnt, done_cyc);
        end
        asserts++;
        if (overflow !== 1'b0 || words_sent !== 32'd2) begin
            failures++;
            $display("FAIL b2b_final: overflow=%b words_sent=%0d required 0 and 2", overflow, words_sent);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w [8];
        logic [7:0]  got;
        logic [7:0]  exp_b;
        int k;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                exp_w[k] = 32'h01020304 + i * 32'h11111111;
                k++;
            end
        end
        clear_log();
        tx_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h01020304 + i * 32'h11111111);
        asserts++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_before: overflow=%b after 4 words, required 0", overflow);
        end
        push_word(32'h01020304 + 4 * 32'h11111111);
        asserts++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after: overflow=%b after 5th word, required 1", overflow);
        end
        len_in = 32'd8;
        len_valid = 1'b1;
        step();
        len_valid = 1'b0;
        step(5);
        tx_ready = 1'b1;
        step(45);
        for (int i = 5; i < 9; i++) push_word(32'h01020304 + i * 32'h11111111);
        wait_done(200);
        step(2);
        asserts++;
        if (bytes.size() != 32) begin
            failures++;
            $display("FAIL ovf_count: bytes=%0d required 32", bytes.size());
        end
        for (int i = 0; i < 32; i++) begin
            got = (i < bytes.size()) ? bytes[i] : 8'hxx;
            exp_b = exp_w[i/4][31-8*(i%4) -: 8];
            asserts++;
            if (got !== exp_b) begin
                failures++;
                $display("FAIL ovf_byte%0d: got %h required %h", i, got, exp_b);
            end
        end
        asserts++;
        if (done_cnt != 1 || words_sent !== 32'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_final: done_cnt=%0d words_sent=%0d overflow=%b required 1, 8, 1", done_cnt, words_sent, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        logic [7:0]  got;
        int n;
        clear_log();
        tx_ready = 1'b1;
        begin_session(32'd1);
        push_word(32'hCAFEBABE);
        n = 0;
        while (bytes.size() < 2 && n < 50) begin
            step();
            n++;
        end
        rst = 1'b1;
        #1;
        asserts++;
        if (bytes.size() != 2) begin
            failures++;
            $display("FAIL rstmid_pos: bytes before reset=%0d required 2", bytes.size());
        end
        asserts++;
        if ({tx_start, done, busy, overflow} !== 4'b0000 || tx_data !== 8'h00 || words_sent !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: ctrl=%b tx_data=%h words_sent=%0d required all 0", {tx_start, done, busy, overflow}, tx_data, words_sent);
        end
        step(3);
        rst = 1'b0;
        step(20);
        asserts++;
        if (bytes.size() != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: bytes=%0d busy=%b required 2 and 0", bytes.size(), busy);
        end
        w = 32'h5A5B5C5D;
        clear_log();
        begin_session(32'd1);
        push_word(w);
        wait_done(60);
        step(2);
        for (int i = 0; i < 4; i++) begin
            got = (i < bytes.size()) ? bytes[i] : 8'hxx;
            asserts++;
            if (got !== w[31-8*i -: 8]) begin
                failures++;
                $display("FAIL rstmid_byte%0d: got %h required %h", i, got, w[31-8*i -: 8]);
            end
        end
        asserts++;
        if (bytes.size() != 4 || done_cnt != 1 || words_sent !== 32'd1) begin
            failures++;
            $display("FAIL rstmid_session: bytes=%0d done_cnt=%0d words_sent=%0d required 4, 1, 1", bytes.size(), done_cnt, words_sent);
        end
    endtask

    task automatic test_zero_strip();
        logic [7:0] exp_b [$];
        logic [7:0] got;
`ifdef DECRYPTER_OUT_ZERO_STRIP_EN
        exp_b = '{8'h48, 8'h69};
`else
        exp_b = '{8'h00, 8'h00, 8'h48, 8'h69};
`endif
        clear_log();
        tx_ready = 1'b1;
        begin_session(32'd1);
        push_word(32'h00004869);
        wait_done(60);
        step(2);
        asserts++;
        if (bytes.size() != exp_b.size()) begin
            failures++;
            $display("FAIL strip_count: bytes=%0d required %0d", bytes.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size(); i++) begin
            got = (i < bytes.size()) ? bytes[i] : 8'hxx;
            asserts++;
            if (got !== exp_b[i]) begin
                failures++;
                $display("FAIL strip_byte%0d: got %h required %h", i, got, exp_b[i]);
            end
        end
        asserts++;
        if (done_cnt != 1 || words_sent !== 32'd1) begin
            failures++;
            $display("FAIL strip_done: done_cnt=%0d words_sent=%0d required 1 and 1", done_cnt, words_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_len();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_zero_strip();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
